dm_bus_ctrl: RTL

- Data-memory interface stage directly downstream of the pipelined core's MEM stage.
- Consumes the core's address, store data, write strobe and DMType.
- Drives a word-wide RAM/MIO bus with byte enables and a ready/ack handshake, holding the pipeline (stall) through wait states.
- Returns lane-aligned, sign/zero-extended load data to the MEM/WB register, and flags misaligned accesses and bus timeouts.

---
 rtl/dm_bus_ctrl_pkg.sv | 48 ++++
 rtl/dm_lane_align.sv | 64 ++++++
 rtl/dm_bus_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/dm_bus_ctrl_pkg.sv
`default_nettype none
//==============================================================================
// Module      : dm_bus_ctrl_pkg
// Description : Shared encodings for the data-memory bus controller:
//               DMType access codes, access-size classes, FSM state encoding
//               and small decode helpers used by dm_bus_ctrl / dm_lane_align.
// Revision    : 1.0 - initial release
//==============================================================================
package dm_bus_ctrl_pkg;

   // DMType codes driven by the core's MEM stage
   typedef enum logic [2:0] {
      DM_WORD   = 3'b000,
      DM_HALF   = 3'b001,
      DM_HALF_U = 3'b010,
      DM_BYTE   = 3'b011,
      DM_BYTE_U = 3'b100
   } dm_type_e;

   // Access size class after decoding a DMType code
   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } dm_size_e;

   // Bus controller FSM states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } dm_state_e;

   // Unlisted codes fall back to a word access.
   function automatic dm_size_e dm_size(input logic [2:0] dmtype);
      case (dmtype)
         DM_HALF, DM_HALF_U: return SZ_HALF;
         DM_BYTE, DM_BYTE_U: return SZ_BYTE;
         default:            return SZ_WORD;
      endcase
   endfunction

   function automatic logic dm_is_signed(input logic [2:0] dmtype);
      return (dmtype == DM_HALF) || (dmtype == DM_BYTE);
   endfunction

endpackage : dm_bus_ctrl_pkg
`default_nettype wire

// File: rtl/dm_lane_align.sv
`default_nettype none
//==============================================================================
// Module      : dm_lane_align
// Description : Combinational byte-lane steering for the data-memory bus.
//               Produces byte enables, lane-replicated store data,
//               lane-extracted sign/zero-extended load data and the
//               misalignment flag for a given byte offset and DMType.
// Ports       : offset_i    - byte offset within the word (addr[1:0])
//               dmtype_i    - DMType access code
//               wdata_i     - right-justified store data
//               rdata_raw_i - raw word from the bus
//               be_o        - byte enables
//               wdata_o     - store data placed in the enabled lanes
//               rdata_o     - extracted and extended load data
//               misaligned_o- access violates its natural alignment
// Revision    : 1.0 - initial release
//==============================================================================
module dm_lane_align
   import dm_bus_ctrl_pkg::*;
(
   input  logic [1:0]  offset_i,
   input  logic [2:0]  dmtype_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_raw_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o,
   output logic        misaligned_o
);

   dm_size_e    w_size;
   logic        w_signed;
   logic [31:0] w_lane;

   always_comb begin
      w_size       = dm_size(dmtype_i);
      w_signed     = dm_is_signed(dmtype_i);
      // Shift the addressed lane down to bit 0 before extension.
      w_lane       = rdata_raw_i >> {offset_i, 3'b000};
      be_o         = 4'b1111;
      wdata_o      = wdata_i;
      rdata_o      = rdata_raw_i;
      misaligned_o = 1'b0;
      case (w_size)
         SZ_BYTE: begin
            be_o    = 4'b0001 << offset_i;
            // Replication puts the byte in every lane; be selects the one used.
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = {{24{w_signed & w_lane[7]}}, w_lane[7:0]};
         end
         SZ_HALF: begin
            be_o         = 4'b0011 << offset_i;
            wdata_o      = {2{wdata_i[15:0]}};
            rdata_o      = {{16{w_signed & w_lane[15]}}, w_lane[15:0]};
            misaligned_o = offset_i[0];
         end
         default: begin
            misaligned_o = |offset_i;
         end
      endcase
   end

endmodule : dm_lane_align
`default_nettype wire

// File: rtl/dm_bus_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : dm_bus_ctrl
// Description : Data-memory interface stage behind the core's MEM stage.
//               Converts a load/store request into a word-wide bus
//               transaction with byte enables, stalls the pipeline through
//               wait states, returns extended load data and reports
//               misaligned requests and bus timeouts.
// Config      : DM_POSTED_WRITE_EN - when defined, aligned stores do not
//               stall; later requests wait for the posted write's ack.
// Ports       : clk_i/reset_ni       - clock, async active-low reset
//               req_*_i              - MEM-stage request
//               rdata_o              - load data, valid in the DONE cycle
//               stall_o              - hold the pipeline
//               misalign_err_o       - pulse on a misaligned request
//               bus_err_o            - pulse on a bus timeout
//               bus_*_o / bus_*_i    - RAM/MIO bus with ready/ack handshake
// Revision    : 1.0 - initial release
//==============================================================================
module dm_bus_ctrl
   import dm_bus_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int ADDR_W         = 32
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              req_valid_i,
   input  logic              req_we_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [31:0]       req_wdata_i,
   input  logic [2:0]        req_dmtype_i,
   output logic [31:0]       rdata_o,
   output logic              stall_o,
   output logic              misalign_err_o,
   output logic              bus_err_o,
   output logic              bus_req_o,
   output logic              bus_we_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [3:0]        bus_be_o,
   output logic [31:0]       bus_wdata_o,
   input  logic              bus_ack_i,
   input  logic [31:0]       bus_rdata_i
);

   localparam int C_CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   dm_state_e          state_q, state_d;
   logic [C_CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]        rdata_q, rdata_d;
   logic [ADDR_W-1:0]  addr_q;
   logic [3:0]         be_q;
   logic [31:0]        wdata_q;
   logic               we_q;
   logic [2:0]         dmtype_q;
   logic [1:0]         offset_q;
`ifdef DM_POSTED_WRITE_EN
   logic               posted_q, posted_d;
`endif

   logic               w_load;
   logic               w_stall;
   logic               w_misalign;
   logic               w_bus_err;
   logic               w_timeout;
   dm_state_e          w_end_state;
   logic [1:0]         w_align_off;
   logic [2:0]         w_align_type;
   logic [3:0]         w_be;
   logic [31:0]        w_wdata_sh;
   logic [31:0]        w_rdata_ext;
   logic               w_misaligned;

   // In IDLE the aligner looks at the live request; afterwards it formats
   // the returning read word with the offset/type captured at launch.
   assign w_align_off  = (state_q == ST_IDLE) ? req_addr_i[1:0] : offset_q;
   assign w_align_type = (state_q == ST_IDLE) ? req_dmtype_i    : dmtype_q;

   dm_lane_align u_lane_align (
      .offset_i     (w_align_off),
      .dmtype_i     (w_align_type),
      .wdata_i      (req_wdata_i),
      .rdata_raw_i  (bus_rdata_i),
      .be_o         (w_be),
      .wdata_o      (w_wdata_sh),
      .rdata_o      (w_rdata_ext),
      .misaligned_o (w_misaligned)
   );

   // Timeout fires in the ACCESS cycle whose count reaches TIMEOUT_CYCLES.
   assign w_timeout = (TIMEOUT_CYCLES != 0) &&
                      ((32'(cnt_q) + 32'd1) == 32'(TIMEOUT_CYCLES));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rdata_d     = rdata_q;
      w_load      = 1'b0;
      w_stall     = 1'b0;
      w_misalign  = 1'b0;
      w_bus_err   = 1'b0;
      w_end_state = ST_DONE;
`ifdef DM_POSTED_WRITE_EN
      posted_d    = posted_q;
      // A posted write returns straight to IDLE; new requests wait on it.
      if (posted_q) begin
         w_end_state = ST_IDLE;
      end
`endif
      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               if (w_misaligned) begin
                  w_misalign = 1'b1;
               end else begin
                  w_load  = 1'b1;
                  cnt_d   = '0;
                  state_d = ST_ACCESS;
`ifdef DM_POSTED_WRITE_EN
                  posted_d = req_we_i;
                  w_stall  = ~req_we_i;
`else
                  w_stall  = 1'b1;
`endif
               end
            end
         end
         ST_ACCESS: begin
`ifdef DM_POSTED_WRITE_EN
            w_stall = posted_q ? req_valid_i : 1'b1;
`else
            w_stall = 1'b1;
`endif
            cnt_d = cnt_q + C_CNT_W'(1);
            // Ack takes priority over a timeout landing on the same cycle.
            if (bus_ack_i) begin
               if (!we_q) begin
                  rdata_d = w_rdata_ext;
               end
               state_d = w_end_state;
            end else if (w_timeout) begin
               w_bus_err = 1'b1;
               rdata_d   = '0;
               state_d   = w_end_state;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         rdata_q  <= '0;
         addr_q   <= '0;
         be_q     <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         dmtype_q <= '0;
         offset_q <= '0;
`ifdef DM_POSTED_WRITE_EN
         posted_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
`ifdef DM_POSTED_WRITE_EN
         posted_q <= posted_d;
`endif
         if (w_load) begin
            addr_q   <= {req_addr_i[ADDR_W-1:2], 2'b00};
            be_q     <= w_be;
            wdata_q  <= w_wdata_sh;
            we_q     <= req_we_i;
            dmtype_q <= req_dmtype_i;
            offset_q <= req_addr_i[1:0];
         end
      end
   end

   assign bus_req_o      = (state_q == ST_ACCESS);
   assign bus_we_o       = bus_req_o & we_q;
   assign bus_addr_o     = addr_q;
   assign bus_be_o       = be_q;
   assign bus_wdata_o    = wdata_q;
   assign rdata_o        = rdata_q;
   // Request-driven outputs are forced low while reset is held.
   assign stall_o        = w_stall & reset_ni;
   assign misalign_err_o = w_misalign & reset_ni;
   assign bus_err_o      = w_bus_err;

endmodule : dm_bus_ctrl
`default_nettype wire
